// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Optional feature macro used by this slice: WB_BYPASS_EN.
package wb_pkg;

  localparam int DATA_W      = 32;
  localparam int REG_W       = 5;
  localparam int RSTATUS_REG = 30;
  localparam int EXC_MUL     = 4;
  localparam int EXC_DIV     = 5;

  // One candidate regfile write.
  typedef struct packed {
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // Which producer owns the output register this cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_MD   = 2'd1,
    SRC_FIFO = 2'd2,
    SRC_PIPE = 2'd3
  } wb_src_e;

  // A multdiv exception replaces the result with a status code aimed at rstatus.
  function automatic wb_req_t md_to_req(input logic              exc,
                                        input logic              is_div,
                                        input logic [REG_W-1:0]  rd,
                                        input logic [DATA_W-1:0] data);
    wb_req_t r;
    r.valid = 1'b1;
    if (exc) begin
      r.rd   = REG_W'(RSTATUS_REG);
      r.data = is_div ? DATA_W'(EXC_DIV) : DATA_W'(EXC_MUL);
    end else begin
      r.rd   = rd;
      r.data = data;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the producer-facing and regfile-facing signals of the writeback arbiter.
// Latency: n/a (wiring only).
// Backpressure: pipe_valid/pipe_ready handshake; md_* is never stalled.
// Ports: pipe_* (in-order producer), md_* (multdiv producer), ctrl_writeEnable/ctrl_writeReg/
// data_writeReg (regfile port), byp_* lookup signals only when WB_BYPASS_EN is defined.
// master = producers/regfile side (testbench), slave = the arbiter.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic              pipe_valid;
  logic              pipe_ready;
  logic [REG_W-1:0]  pipe_rd;
  logic [DATA_W-1:0] pipe_data;

  logic              md_done;
  logic [REG_W-1:0]  md_rd;
  logic [DATA_W-1:0] md_data;
  logic              md_exception;
  logic              md_is_div;

  logic              ctrl_writeEnable;
  logic [REG_W-1:0]  ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;

`ifdef WB_BYPASS_EN
  logic [REG_W-1:0]  byp_rd_a;
  logic [REG_W-1:0]  byp_rd_b;
  logic              byp_hit_a;
  logic              byp_hit_b;
  logic [DATA_W-1:0] byp_data_a;
  logic [DATA_W-1:0] byp_data_b;
`endif

  modport master (
    output pipe_valid, pipe_rd, pipe_data,
    output md_done, md_rd, md_data, md_exception, md_is_div,
`ifdef WB_BYPASS_EN
    output byp_rd_a, byp_rd_b,
    input  byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
`endif
    input  pipe_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

  modport slave (
    input  pipe_valid, pipe_rd, pipe_data,
    input  md_done, md_rd, md_data, md_exception, md_is_div,
`ifdef WB_BYPASS_EN
    input  byp_rd_a, byp_rd_b,
    output byp_hit_a, byp_hit_b, byp_data_a, byp_data_b,
`endif
    output pipe_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

endinterface

// File: rtl/wb_fifo.sv
// Small in-order FIFO of parked pipeline writes; head is combinational from storage.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: push is ignored when full unless popping the same cycle; pop ignored when empty.
// Ports: clock, ctrl_reset_n, i_push/i_push_dat, i_pop, o_head_dat, o_count, o_empty,
// and o_tap (oldest-to-youngest view, valid-masked) when WB_BYPASS_EN is defined.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             i_push,
  input  wb_req_t          i_push_dat,
  input  logic             i_pop,
  output wb_req_t          o_head_dat,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
`ifdef WB_BYPASS_EN
  ,
  output wb_req_t          o_tap [DEPTH]
`endif
);

  wb_req_t          r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_full;
  logic             w_push_ok;
  logic             w_pop_ok;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_pop_ok  = i_pop & ~o_empty;
  // A push at full is only legal because the pop frees the slot this same cycle.
  assign w_push_ok = i_push & (~w_full | w_pop_ok);

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_next(r_rd_ptr);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CNT_W'(1);
      else if (w_pop_ok && !w_push_ok) r_count <= r_count - CNT_W'(1);
    end
  end

  // Storage carries no reset; occupancy is tracked entirely by r_count.
  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

`ifdef WB_BYPASS_EN
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_tap[i]       = r_mem[PTR_W'((int'(r_rd_ptr) + i) % DEPTH)];
      o_tap[i].valid = (i < int'(r_count));
    end
  end
`endif

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges pipeline and multdiv writes onto the single regfile write port.
// Latency: the selected write is registered, appearing on the regfile port 1 cycle later.
// Backpressure: pipe_ready drops only when the park FIFO is full and not draining; md never stalls.
// Ports: clock, ctrl_reset_n (async, active-low), bus (wb_arbiter_if.slave).
// Optional feature: WB_BYPASS_EN adds a combinational youngest-pending-write lookup on byp_*.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic         clock,
  input  logic         ctrl_reset_n,
  wb_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic              r_rdy_en;
  logic              r_we;
  logic [REG_W-1:0]  r_reg;
  logic [DATA_W-1:0] r_data;

  wb_req_t           w_head;
  wb_req_t           w_md_req;
  wb_req_t           w_pipe_req;
  wb_req_t           w_sel;
  wb_src_e           w_src;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_accept;
  logic              w_ready;

  // Held low through reset and released on the first clock after it.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) r_rdy_en <= 1'b0;
    else               r_rdy_en <= 1'b1;
  end

  // The FIFO head drains whenever multdiv is not claiming the port.
  assign w_pop    = ~w_empty & ~bus.md_done;
  assign w_ready  = r_rdy_en & ((w_count < CNT_W'(FIFO_DEPTH)) | w_pop);
  assign w_accept = bus.pipe_valid & w_ready;
  // Park the pipe write if multdiv wins, or if older pipe writes are still queued
  // (bypassing them would reorder the in-order stream).
  assign w_push   = w_accept & (bus.md_done | ~w_empty);

  assign w_md_req   = md_to_req(bus.md_exception, bus.md_is_div, bus.md_rd, bus.md_data);
  assign w_pipe_req = '{valid: 1'b1, rd: bus.pipe_rd, data: bus.pipe_data};

  always_comb begin
    w_src = SRC_NONE;
    if (bus.md_done)   w_src = SRC_MD;
    else if (!w_empty) w_src = SRC_FIFO;
    else if (w_accept) w_src = SRC_PIPE;
  end

  always_comb begin
    w_sel = '0;
    case (w_src)
      SRC_MD:   w_sel = w_md_req;
      SRC_FIFO: w_sel = w_head;
      SRC_PIPE: w_sel = w_pipe_req;
      default:  w_sel = '0;
    endcase
  end

  // A write to r0 still consumes its slot but never raises the enable.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_we   <= 1'b0;
      r_reg  <= '0;
      r_data <= '0;
    end else begin
      r_we   <= w_sel.valid & (w_sel.rd != '0);
      r_reg  <= w_sel.rd;
      r_data <= w_sel.data;
    end
  end

`ifdef WB_BYPASS_EN
  wb_req_t w_tap [FIFO_DEPTH];
`endif

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .i_push       (w_push),
    .i_push_dat   (w_pipe_req),
    .i_pop        (w_pop),
    .o_head_dat   (w_head),
    .o_count      (w_count),
    .o_empty      (w_empty)
`ifdef WB_BYPASS_EN
    ,
    .o_tap        (w_tap)
`endif
  );

  assign bus.pipe_ready       = w_ready;
  assign bus.ctrl_writeEnable = r_we;
  assign bus.ctrl_writeReg    = r_reg;
  assign bus.data_writeReg    = r_data;

`ifdef WB_BYPASS_EN
  // Youngest pending write wins: the output register is the fallback, then FIFO
  // entries overwrite it oldest-to-youngest so the tail has the final say.
  function automatic logic [DATA_W:0] byp_lookup(input logic [REG_W-1:0] rd);
    logic [DATA_W:0] res;
    res = '0;
    if (rd != '0) begin
      if (r_we && (r_reg == rd)) res = {1'b1, r_data};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (w_tap[i].valid && (w_tap[i].rd == rd)) res = {1'b1, w_tap[i].data};
      end
    end
    return res;
  endfunction

  assign {bus.byp_hit_a, bus.byp_data_a} = byp_lookup(bus.byp_rd_a);
  assign {bus.byp_hit_b, bus.byp_data_b} = byp_lookup(bus.byp_rd_b);
`endif

endmodule
